sys_ctrl: RTL and testbench

- Command sequencer between the UART receive path and the register file, ALU and UART transmit path.
- Decodes byte frames: 0xAA reg write, 0xBB reg read, 0xCC ALU with operands, 0xDD ALU without operands.
- Drives register-file and ALU strobes, gates the ALU clock, and returns read data or ALU results to the UART TX, one byte at a time.

---
 rtl/sys_ctrl_pkg.sv | 39 +++
 rtl/sys_ctrl_tx_seq.sv | 92 +++++++++
 rtl/sys_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_sys_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared definitions for the command sequencer.
//   - frame command bytes and ALU operand register addresses
//   - decoder and transmit-serializer state encodings
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [3:0] OPA_ADDR = 4'h0;
  localparam logic [3:0] OPB_ADDR = 4'h1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FN,
    ST_ALU_WAIT,
    ST_TX
  } ctrl_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT_ACC,
    TX_WAIT_DONE
  } tx_state_e;

  function automatic logic good_byte(input logic vld, input logic par_err,
                                     input logic stp_err);
    return vld & ~par_err & ~stp_err;
  endfunction

endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// sys_ctrl_tx_seq: serializes a 1- or 2-byte response onto the UART TX path.
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_start         level request; accepted only when idle
//   i_two_bytes     1: send low then high byte, 0: low byte only
//   i_data          response word, held stable by the caller until o_done
//   i_tx_busy       transmitter busy
//   o_tx_data       byte to transmit
//   o_tx_vld        one-cycle transmit request
//   o_done          one-cycle pulse when the last byte has been transmitted
module sys_ctrl_tx_seq
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ALU_OUT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_two_bytes,
  input  logic [ALU_OUT_WIDTH-1:0] i_data,
  input  logic                     i_tx_busy,
  output logic [DATA_WIDTH-1:0]    o_tx_data,
  output logic                     o_tx_vld,
  output logic                     o_done
);

  tx_state_e             r_state, w_state_nxt;
  logic                  r_hi, w_hi_nxt;
  logic                  r_vld, w_vld_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  w_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= TX_IDLE;
      r_hi    <= 1'b0;
      r_vld   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_vld   <= w_vld_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Each byte: request while the transmitter is idle, then see it go busy
  // (accepted) and idle again (finished) before moving on.
  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_vld_nxt   = 1'b0;
    w_data_nxt  = r_data;
    w_done      = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (i_start) begin
          w_hi_nxt    = 1'b0;
          w_state_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!i_tx_busy) begin
          w_vld_nxt   = 1'b1;
          w_data_nxt  = r_hi ? i_data[DATA_WIDTH +: DATA_WIDTH]
                             : i_data[DATA_WIDTH-1:0];
          w_state_nxt = TX_WAIT_ACC;
        end
      end
      TX_WAIT_ACC: begin
        if (i_tx_busy) w_state_nxt = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: begin
        if (!i_tx_busy) begin
          if (i_two_bytes && !r_hi) begin
            w_hi_nxt    = 1'b1;
            w_state_nxt = TX_SEND;
          end else begin
            w_done      = 1'b1;
            w_state_nxt = TX_IDLE;
          end
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  assign o_tx_data = r_data;
  assign o_tx_vld  = r_vld;
  assign o_done    = w_done;

endmodule

// File: rtl/sys_ctrl.sv
// sys_ctrl: command sequencer between UART RX, register file, ALU and UART TX.
//   Frames: AA addr data (write), BB addr (read), CC a b fn (ALU with
//   operands), DD fn (ALU on stored operands).
//   REF_CLK, rst                     clock, asynchronous active-high reset
//   RX_P_DATA/RX_D_VLD/PAR_ERR/STP_ERR  received byte and its qualifiers
//   WrEn/RdEn/Address/WrData/RdData/RdData_Valid  register-file port
//   ALU_EN/ALU_FUN/CLK_EN/ALU_OUT/OUT_VALID       ALU control and result
//   TX_P_DATA/TX_D_VLD/TX_BUSY                    UART transmit port
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned ALU_OUT_WIDTH = 16,
  parameter int unsigned ALU_TIMEOUT   = 255
) (
  input  logic                     REF_CLK,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic                     PAR_ERR,
  input  logic                     STP_ERR,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  output logic                     ALU_EN,
  output logic [3:0]               ALU_FUN,
  output logic                     CLK_EN,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_VALID,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  input  logic                     TX_BUSY
);

  localparam int unsigned     TMO_W    = $clog2(ALU_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ALU_TIMEOUT - 1);

  ctrl_state_e              r_state, w_state_nxt;
  logic                     r_wr_en, w_wr_en_nxt;
  logic                     r_rd_en, w_rd_en_nxt;
  logic [ADDR_WIDTH-1:0]    r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0]    r_wr_data, w_wr_data_nxt;
  logic                     r_alu_en, w_alu_en_nxt;
  logic [3:0]               r_alu_fun, w_alu_fun_nxt;
  logic                     r_clk_en, w_clk_en_nxt;
  logic [ALU_OUT_WIDTH-1:0] r_result, w_result_nxt;
  logic                     r_two_bytes, w_two_bytes_nxt;
  logic [TMO_W-1:0]         r_tmo, w_tmo_nxt;

  logic w_good, w_bad, w_tx_start, w_tx_done;

  assign w_good = good_byte(RX_D_VLD, PAR_ERR, STP_ERR);
  assign w_bad  = RX_D_VLD & (PAR_ERR | STP_ERR);

  always_ff @(posedge REF_CLK or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_alu_en    <= 1'b0;
      r_alu_fun   <= '0;
      r_clk_en    <= 1'b0;
      r_result    <= '0;
      r_two_bytes <= 1'b0;
      r_tmo       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_addr      <= w_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_alu_en    <= w_alu_en_nxt;
      r_alu_fun   <= w_alu_fun_nxt;
      r_clk_en    <= w_clk_en_nxt;
      r_result    <= w_result_nxt;
      r_two_bytes <= w_two_bytes_nxt;
      r_tmo       <= w_tmo_nxt;
    end
  end

  // Strobes are computed here and registered, so each appears in the cycle
  // after the byte that triggers it and lasts exactly one cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_en_nxt     = 1'b0;
    w_rd_en_nxt     = 1'b0;
    w_alu_en_nxt    = 1'b0;
    w_addr_nxt      = r_addr;
    w_wr_data_nxt   = r_wr_data;
    w_alu_fun_nxt   = r_alu_fun;
    w_clk_en_nxt    = r_clk_en;
    w_result_nxt    = r_result;
    w_two_bytes_nxt = r_two_bytes;
    w_tmo_nxt       = r_tmo;
    case (r_state)
      ST_IDLE: begin
        if (w_good) begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_WR))           w_state_nxt = ST_WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_RD))      w_state_nxt = ST_RD_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  w_state_nxt = ST_ALU_A;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) w_state_nxt = ST_ALU_FN;
        end
      end
      ST_WR_ADDR: begin
        if (w_good) begin
          w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
          w_state_nxt = ST_WR_DATA;
        end else if (w_bad) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (w_good) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_data_nxt = RX_P_DATA;
          w_state_nxt   = ST_IDLE;
        end else if (w_bad) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (w_good) begin
          w_rd_en_nxt = 1'b1;
          w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
          w_state_nxt = ST_RD_WAIT;
        end else if (w_bad) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (RdData_Valid) begin
          w_result_nxt    = ALU_OUT_WIDTH'(RdData);
          w_two_bytes_nxt = 1'b0;
          w_state_nxt     = ST_TX;
        end
      end
      ST_ALU_A: begin
        if (w_good) begin
          w_wr_en_nxt   = 1'b1;
          w_addr_nxt    = ADDR_WIDTH'(OPA_ADDR);
          w_wr_data_nxt = RX_P_DATA;
          w_state_nxt   = ST_ALU_B;
        end else if (w_bad) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ALU_B: begin
        if (w_good) begin
          w_wr_en_nxt   = 1'b1;
          w_addr_nxt    = ADDR_WIDTH'(OPB_ADDR);
          w_wr_data_nxt = RX_P_DATA;
          w_state_nxt   = ST_ALU_FN;
        end else if (w_bad) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ALU_FN: begin
        if (w_good) begin
          w_alu_fun_nxt = RX_P_DATA[3:0];
          w_clk_en_nxt  = 1'b1;
          w_alu_en_nxt  = 1'b1;
          w_tmo_nxt     = '0;
          w_state_nxt   = ST_ALU_WAIT;
        end else if (w_bad) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ALU_WAIT: begin
        // A result arriving in the last allowed cycle still wins over abort;
        // the gated clock stays on for exactly ALU_TIMEOUT cycles otherwise.
        if (OUT_VALID) begin
          w_result_nxt    = ALU_OUT;
          w_two_bytes_nxt = 1'b1;
          w_clk_en_nxt    = 1'b0;
          w_state_nxt     = ST_TX;
        end else if (r_tmo == TMO_LAST) begin
          w_clk_en_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      ST_TX: begin
        if (w_tx_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The serializer ignores start while busy, so holding it for the whole
  // TX state starts exactly one response.
  assign w_tx_start = (r_state == ST_TX);

  sys_ctrl_tx_seq #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ALU_OUT_WIDTH (ALU_OUT_WIDTH)
  ) u_tx_seq (
    .i_clk       (REF_CLK),
    .i_rst       (rst),
    .i_start     (w_tx_start),
    .i_two_bytes (r_two_bytes),
    .i_data      (r_result),
    .i_tx_busy   (TX_BUSY),
    .o_tx_data   (TX_P_DATA),
    .o_tx_vld    (TX_D_VLD),
    .o_done      (w_tx_done)
  );

  assign WrEn    = r_wr_en;
  assign RdEn    = r_rd_en;
  assign Address = r_addr;
  assign WrData  = r_wr_data;
  assign ALU_EN  = r_alu_en;
  assign ALU_FUN = r_alu_fun;
  assign CLK_EN  = r_clk_en;

endmodule

// File: tb/tb_sys_ctrl.sv
module tb_sys_ctrl;

  logic        REF_CLK;
  logic        rst;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD, PAR_ERR, STP_ERR;
  logic        WrEn, RdEn;
  logic [3:0]  Address;
  logic [7:0]  WrData;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_EN;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY;

  sys_ctrl #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .ALU_OUT_WIDTH (16),
    .ALU_TIMEOUT   (255)
  ) dut (
    .REF_CLK      (REF_CLK),
    .rst          (rst),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .PAR_ERR      (PAR_ERR),
    .STP_ERR      (STP_ERR),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .ALU_EN       (ALU_EN),
    .ALU_FUN      (ALU_FUN),
    .CLK_EN       (CLK_EN),
    .ALU_OUT      (ALU_OUT),
    .OUT_VALID    (OUT_VALID),
    .TX_P_DATA    (TX_P_DATA),
    .TX_D_VLD     (TX_D_VLD),
    .TX_BUSY      (TX_BUSY)
  );

  initial begin
    REF_CLK = 1'b0;
    forever #5 REF_CLK = ~REF_CLK;
  end

  // Observable events: 0 reg write (a=addr,b=data), 1 reg read (a=addr),
  // 2 ALU start (a=function), 3 transmitted byte (a=byte).
  typedef struct {
    int         kind;
    logic [7:0] a;
    logic [7:0] b;
  } ev_t;

  typedef struct {
    bit          respond;
    logic [15:0] val;
  } alu_plan_t;

  ev_t        sb_q[$];
  alu_plan_t  alu_q[$];
  logic [7:0] ref_mem[16];
  logic [7:0] rf_mem[16];
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         tx_active = 0;
  int         clk_run = 0;
  int         last_run = 0;

  function automatic void push_ev(input int k, input logic [7:0] a, input logic [7:0] b);
    ev_t e;
    e.kind = k;
    e.a = a;
    e.b = b;
    sb_q.push_back(e);
  endfunction

  function automatic void plan_alu(input bit respond, input logic [15:0] val);
    alu_plan_t p;
    p.respond = respond;
    p.val = val;
    alu_q.push_back(p);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input logic [7:0] a, input logic [7:0] b, input string nm);
    ev_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got unexpected event a=%h b=%h, required no event", nm, a, b);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d a=%h b=%h, required kind=%0d a=%h b=%h",
                 nm, k, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Monitor: every DUT strobe is matched against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge REF_CLK);
      if (!rst) begin
        if (WrEn && RdEn) begin
          n_cmp++; n_fail++;
          $display("FAIL wr_rd_excl: got WrEn=1 RdEn=1, required not both");
        end
        if (ALU_EN && !CLK_EN) begin
          n_cmp++; n_fail++;
          $display("FAIL alu_en_gate: got ALU_EN=1 CLK_EN=0, required CLK_EN=1");
        end
        if (TX_D_VLD && TX_BUSY) begin
          n_cmp++; n_fail++;
          $display("FAIL tx_while_busy: got TX_D_VLD=1 TX_BUSY=1, required TX_BUSY=0");
        end
        if (WrEn)     expect_ev(0, 8'(Address), WrData, "wr_strobe");
        if (RdEn)     expect_ev(1, 8'(Address), 8'h00, "rd_strobe");
        if (ALU_EN)   expect_ev(2, 8'(ALU_FUN), 8'h00, "alu_start");
        if (TX_D_VLD) expect_ev(3, TX_P_DATA, 8'h00, "tx_byte");
      end
    end
  end

  initial begin
    forever begin
      @(negedge REF_CLK);
      if (CLK_EN) clk_run++;
      else if (clk_run != 0) begin
        last_run = clk_run;
        clk_run = 0;
      end
    end
  end

  // Register-file responder.
  initial begin : rf_resp
    logic [3:0] ad;
    forever begin
      @(negedge REF_CLK);
      if (!rst && WrEn) rf_mem[Address] = WrData;
      if (!rst && RdEn) begin
        ad = Address;
        repeat ($urandom_range(1, 3)) @(posedge REF_CLK);
        #1;
        RdData = rf_mem[ad];
        RdData_Valid = 1'b1;
        @(posedge REF_CLK);
        #1;
        RdData_Valid = 1'b0;
      end
    end
  end

  // ALU responder, following the plan queued by the stimulus.
  initial begin : alu_resp
    alu_plan_t p;
    forever begin
      @(negedge REF_CLK);
      if (!rst && ALU_EN) begin
        if (alu_q.size() == 0) p.respond = 1'b0;
        else p = alu_q.pop_front();
        if (p.respond) begin
          repeat ($urandom_range(1, 8)) @(posedge REF_CLK);
          #1;
          ALU_OUT = p.val;
          OUT_VALID = 1'b1;
          @(posedge REF_CLK);
          #1;
          OUT_VALID = 1'b0;
        end
      end
    end
  end

  // UART TX responder: accepts a byte after a delay, then stays busy a while.
  initial begin
    forever begin
      @(negedge REF_CLK);
      if (!rst && TX_D_VLD) begin
        tx_active = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge REF_CLK);
        #1 TX_BUSY = 1'b1;
        repeat ($urandom_range(1, 5)) @(posedge REF_CLK);
        #1 TX_BUSY = 1'b0;
        tx_active = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit pe = 1'b0, input bit se = 1'b0);
    @(posedge REF_CLK);
    #1;
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    PAR_ERR = pe;
    STP_ERR = se;
    @(posedge REF_CLK);
    #1;
    RX_D_VLD = 1'b0;
    PAR_ERR = 1'b0;
    STP_ERR = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge REF_CLK);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((sb_q.size() != 0 || tx_active || TX_BUSY || RdData_Valid || OUT_VALID) && c < 3000) begin
      @(posedge REF_CLK);
      c++;
    end
    if (c >= 3000) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d events pending, required 0", sb_q.size());
      sb_q.delete();
    end
    repeat (4) @(posedge REF_CLK);
    #1;
  endtask

  function automatic logic [7:0] rand_unknown();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom_range(0, 255));
    return b;
  endfunction

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] a, d, f;
    logic [15:0] res;
    bit pe;
    rst = 1'b1;
    RX_P_DATA = '0; RX_D_VLD = 1'b0; PAR_ERR = 1'b0; STP_ERR = 1'b0;
    RdData = '0; RdData_Valid = 1'b0; ALU_OUT = '0; OUT_VALID = 1'b0; TX_BUSY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'h00;
      rf_mem[i] = 8'h00;
    end
    repeat (3) @(posedge REF_CLK);
    #1;
    chk("rst_WrEn", int'(WrEn), 0);
    chk("rst_RdEn", int'(RdEn), 0);
    chk("rst_Address", int'(Address), 0);
    chk("rst_WrData", int'(WrData), 0);
    chk("rst_ALU_EN", int'(ALU_EN), 0);
    chk("rst_ALU_FUN", int'(ALU_FUN), 0);
    chk("rst_CLK_EN", int'(CLK_EN), 0);
    chk("rst_TX_D_VLD", int'(TX_D_VLD), 0);
    chk("rst_TX_P_DATA", int'(TX_P_DATA), 0);
    rst = 1'b0;

    // Write then read back.
    push_ev(0, 8'h05, 8'h3C); ref_mem[5] = 8'h3C;
    send(8'hAA); send(8'h05); send(8'h3C); drain();
    push_ev(1, 8'h05, 8'h00); push_ev(3, 8'h3C, 8'h00);
    send(8'hBB); send(8'h05); drain();

    // ALU with operands: 0x0A + 0x03.
    push_ev(0, 8'h00, 8'h0A); push_ev(0, 8'h01, 8'h03);
    push_ev(2, 8'h00, 8'h00); push_ev(3, 8'h0D, 8'h00); push_ev(3, 8'h00, 8'h00);
    ref_mem[0] = 8'h0A; ref_mem[1] = 8'h03;
    plan_alu(1'b1, 16'h000D);
    send(8'hCC); send(8'h0A); send(8'h03); send(8'h00); drain();

    // ALU without operands.
    push_ev(2, 8'h02, 8'h00); push_ev(3, 8'h00, 8'h00); push_ev(3, 8'h1E, 8'h00);
    plan_alu(1'b1, 16'h1E00);
    send(8'hDD); send(8'h02); drain();

    // Parity error mid-write aborts; next write completes.
    send(8'hAA); send(8'h05); send(8'h3C, 1'b1, 1'b0); drain();
    push_ev(0, 8'h07, 8'h11); ref_mem[7] = 8'h11;
    send(8'hAA); send(8'h07); send(8'h11); drain();

    // Unknown byte in IDLE is ignored.
    send(8'h12);
    push_ev(1, 8'h07, 8'h00); push_ev(3, 8'h11, 8'h00);
    send(8'hBB); send(8'h07); drain();

    // ALU timeout: gated clock runs exactly 255 cycles, nothing sent.
    last_run = 0;
    push_ev(2, 8'h01, 8'h00);
    plan_alu(1'b0, 16'h0000);
    send(8'hDD); send(8'h01);
    repeat (300) @(posedge REF_CLK);
    #1;
    chk("alu_timeout_clk_en_cycles", last_run, 255);
    chk("alu_timeout_clk_en_low", int'(CLK_EN), 0);
    drain();

    // Reset while waiting on the ALU clears CLK_EN at once.
    push_ev(2, 8'h03, 8'h00);
    plan_alu(1'b0, 16'h0000);
    send(8'hDD); send(8'h03);
    repeat (20) @(posedge REF_CLK);
    chk("alu_wait_clk_en_high", int'(CLK_EN), 1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_CLK_EN", int'(CLK_EN), 0);
    chk("midrst_ALU_FUN", int'(ALU_FUN), 0);
    chk("midrst_Address", int'(Address), 0);
    repeat (2) @(posedge REF_CLK);
    #1 rst = 1'b0;
    drain();

    // Randomized command mix.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          a = 8'($urandom_range(0, 255)); d = 8'($urandom_range(0, 255));
          push_ev(0, {4'h0, a[3:0]}, d); ref_mem[a[3:0]] = d;
          send(8'hAA); send(a); send(d);
        end
        1: begin
          a = 8'($urandom_range(0, 255));
          push_ev(1, {4'h0, a[3:0]}, 8'h00); push_ev(3, ref_mem[a[3:0]], 8'h00);
          send(8'hBB); send(a);
        end
        2: begin
          a = 8'($urandom_range(0, 255)); d = 8'($urandom_range(0, 255));
          f = 8'($urandom_range(0, 255)); res = 16'($urandom_range(0, 65535));
          push_ev(0, 8'h00, a); push_ev(0, 8'h01, d); push_ev(2, {4'h0, f[3:0]}, 8'h00);
          push_ev(3, res[7:0], 8'h00); push_ev(3, res[15:8], 8'h00);
          ref_mem[0] = a; ref_mem[1] = d;
          plan_alu(1'b1, res);
          send(8'hCC); send(a); send(d); send(f);
        end
        3: begin
          f = 8'($urandom_range(0, 255)); res = 16'($urandom_range(0, 65535));
          push_ev(2, {4'h0, f[3:0]}, 8'h00);
          push_ev(3, res[7:0], 8'h00); push_ev(3, res[15:8], 8'h00);
          plan_alu(1'b1, res);
          send(8'hDD); send(f);
        end
        4: begin
          pe = 1'($urandom_range(0, 1));
          a = 8'($urandom_range(0, 255));
          case ($urandom_range(0, 5))
            0: begin send(8'hAA); send(a, pe, ~pe); end
            1: begin send(8'hAA); send(a); send(a, pe, ~pe); end
            2: begin send(8'hBB); send(a, pe, ~pe); end
            3: begin send(8'hCC); send(a, pe, ~pe); end
            4: begin
              push_ev(0, 8'h00, a); ref_mem[0] = a;
              send(8'hCC); send(a); send(a, pe, ~pe);
            end
            default: begin send(8'hDD); send(a, pe, ~pe); end
          endcase
        end
        default: begin
          if ($urandom_range(0, 1) == 0) send(rand_unknown());
          else send(8'hAA, 1'b1, 1'b0);
        end
      endcase
      drain();
    end

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
